// File: rtl/trigger_csr_ctrl.sv
// Purpose : owns tselect/tdata1-3/tinfo for two mcontrol triggers, latches hits, sequences debug halt.
// Latency : CSR ack/rdata/err one cycle after csr_req is sampled; hit -> halt_req one cycle.
// Backpres: csr_req is held by the requester until csr_ack; requests during the ack cycle are ignored.
//
// Ports:
//   cpu_clk, cpu_rst           clock, synchronous active-high reset
//   csr_req/we/addr/wdata      CSR access request from the core
//   csr_ack/rdata/err          one-cycle completion, read data, rejection flag
//   dbg_mode, trig_hit         core debug state, per-trigger comparator match
//   halt_ack                   debug module accepted the halt
//   tdataN_tM                  register contents driven to the comparator
//   halt_req, halt_timeout     halt request level, one-cycle timeout pulse
module trigger_csr_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  csr_req,
    input  logic                  csr_we,
    input  logic [11:0]           csr_addr,
    input  logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  csr_ack,
    output logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_err,
    input  logic                  dbg_mode,
    input  logic [1:0]            trig_hit,
    input  logic                  halt_ack,
    output logic [DATA_WIDTH-1:0] tdata1_t0,
    output logic [DATA_WIDTH-1:0] tdata1_t1,
    output logic [DATA_WIDTH-1:0] tdata2_t0,
    output logic [DATA_WIDTH-1:0] tdata2_t1,
    output logic [DATA_WIDTH-1:0] tdata3_t0,
    output logic [DATA_WIDTH-1:0] tdata3_t1,
    output logic                  halt_req,
    output logic                  halt_timeout
);

    localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
    localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;
    localparam logic [11:0] ADDR_TDATA3  = 12'h7A3;
    localparam logic [11:0] ADDR_TINFO   = 12'h7A4;

    localparam logic [31:0] TDATA1_RST = 32'h2000_0000;
    localparam logic [31:0] TINFO_VAL  = 32'h0000_0004;
    localparam logic [8:0]  TIMEOUT    = 9'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HALT_REQ  = 2'd1,
        WAIT_EXIT = 2'd2
    } state_t;

    // ---------------------------------------------------------------
    // CSR state
    // ---------------------------------------------------------------
    logic             tselect_q, tselect_d;
    logic [1:0][31:0] tdata1_q, tdata1_d;
    logic [1:0][31:0] tdata2_q, tdata2_d;
    logic [1:0][31:0] tdata3_q, tdata3_d;
    logic             csr_ack_q, csr_ack_d;
    logic [31:0]      csr_rdata_q, csr_rdata_d;
    logic             csr_err_q, csr_err_d;

    logic        csr_acc;
    logic [31:0] sel_tdata1;
    logic [31:0] sel_tdata2;
    logic [31:0] sel_tdata3;
    logic        sel_locked;
    logic [3:0]  wr_type;
    logic [31:0] tdata1_wr;

    // The ack cycle blocks a new acceptance, giving the 2-cycle access spacing.
    assign csr_acc    = csr_req && !csr_ack_q;
    assign sel_tdata1 = tdata1_q[tselect_q];
    assign sel_tdata2 = tdata2_q[tselect_q];
    assign sel_tdata3 = tdata3_q[tselect_q];
    // A dmode trigger may only be modified from debug mode.
    assign sel_locked = sel_tdata1[27] && !dbg_mode;

    // WARL type field: only "none" (0) and mcontrol (2) are legal.
    assign wr_type = ((csr_wdata[31:28] == 4'd0) || (csr_wdata[31:28] == 4'd2)) ?
                     csr_wdata[31:28] : 4'd0;

    // hit is clear-only from software: writing 1 keeps the current value.
    assign tdata1_wr = {wr_type,
                        csr_wdata[27] & dbg_mode,
                        csr_wdata[26:21],
                        csr_wdata[20] & sel_tdata1[20],
                        csr_wdata[19:0]};

    always_comb begin
        tselect_d   = tselect_q;
        tdata1_d    = tdata1_q;
        tdata2_d    = tdata2_q;
        tdata3_d    = tdata3_q;
        csr_ack_d   = csr_acc;
        csr_rdata_d = 32'h0;
        csr_err_d   = 1'b0;

        if (csr_acc) begin
            case (csr_addr)
                ADDR_TSELECT: begin
                    if (csr_we) begin
                        // Out-of-range selects are silently ignored.
                        if (csr_wdata[31:1] == 31'h0) begin
                            tselect_d = csr_wdata[0];
                        end
                    end else begin
                        csr_rdata_d = {31'h0, tselect_q};
                    end
                end
                ADDR_TDATA1: begin
                    if (!csr_we)         csr_rdata_d = sel_tdata1;
                    else if (sel_locked) csr_err_d   = 1'b1;
                    else                 tdata1_d[tselect_q] = tdata1_wr;
                end
                ADDR_TDATA2: begin
                    if (!csr_we)         csr_rdata_d = sel_tdata2;
                    else if (sel_locked) csr_err_d   = 1'b1;
                    else                 tdata2_d[tselect_q] = csr_wdata;
                end
                ADDR_TDATA3: begin
                    if (!csr_we)         csr_rdata_d = sel_tdata3;
                    else if (sel_locked) csr_err_d   = 1'b1;
                    else                 tdata3_d[tselect_q] = csr_wdata;
                end
                ADDR_TINFO: begin
                    if (csr_we) csr_err_d   = 1'b1;
                    else        csr_rdata_d = TINFO_VAL;
                end
                default: csr_err_d = 1'b1;
            endcase
        end

        // Hardware hit set is applied last so it overrides a same-cycle software clear;
        // read data above was already taken from the pre-set state.
        for (int i = 0; i < 2; i++) begin
            if (trig_hit[i] && !dbg_mode) begin
                tdata1_d[i][20] = 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            tselect_q   <= 1'b0;
            tdata1_q    <= {TDATA1_RST, TDATA1_RST};
            tdata2_q    <= '0;
            tdata3_q    <= '0;
            csr_ack_q   <= 1'b0;
            csr_rdata_q <= 32'h0;
            csr_err_q   <= 1'b0;
        end else begin
            tselect_q   <= tselect_d;
            tdata1_q    <= tdata1_d;
            tdata2_q    <= tdata2_d;
            tdata3_q    <= tdata3_d;
            csr_ack_q   <= csr_ack_d;
            csr_rdata_q <= csr_rdata_d;
            csr_err_q   <= csr_err_d;
        end
    end

    // ---------------------------------------------------------------
    // Halt sequencing FSM
    // ---------------------------------------------------------------
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        halt_req_q;
    logic        halt_timeout_q;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q        <= IDLE;
            cnt_q          <= 8'h0;
            halt_req_q     <= 1'b0;
            halt_timeout_q <= 1'b0;
        end else begin
            halt_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((|trig_hit) && !dbg_mode) begin
                        state_q    <= HALT_REQ;
                        halt_req_q <= 1'b1;
                        cnt_q      <= 8'h0;
                    end
                end
                HALT_REQ: begin
                    if (halt_ack) begin
                        state_q    <= WAIT_EXIT;
                        halt_req_q <= 1'b0;
                    // cnt_q counts completed request cycles minus one, so the
                    // request is held for exactly ACK_TIMEOUT cycles.
                    end else if (({1'b0, cnt_q} + 9'd1) == TIMEOUT) begin
                        state_q        <= IDLE;
                        halt_req_q     <= 1'b0;
                        halt_timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WAIT_EXIT: begin
                    if (!dbg_mode && !halt_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    halt_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign csr_ack      = csr_ack_q;
    assign csr_rdata    = csr_rdata_q;
    assign csr_err      = csr_err_q;
    assign tdata1_t0    = tdata1_q[0];
    assign tdata1_t1    = tdata1_q[1];
    assign tdata2_t0    = tdata2_q[0];
    assign tdata2_t1    = tdata2_q[1];
    assign tdata3_t0    = tdata3_q[0];
    assign tdata3_t1    = tdata3_q[1];
    assign halt_req     = halt_req_q;
    assign halt_timeout = halt_timeout_q;

endmodule

// File: tb/tb_trigger_csr_ctrl.sv
// Bench for trigger_csr_ctrl: CSR responses are checked by a scoreboard monitor,
// comparator-facing outputs and halt signals are checked directly after each edge.
// Runs with ACK_TIMEOUT = 4.
module tb_trigger_csr_ctrl;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        csr_req = 1'b0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = 12'h0;
    logic [31:0] csr_wdata = 32'h0;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_err;
    logic        dbg_mode = 1'b0;
    logic [1:0]  trig_hit = 2'b00;
    logic        halt_ack = 1'b0;
    logic [31:0] tdata1_t0, tdata1_t1, tdata2_t0, tdata2_t1, tdata3_t0, tdata3_t1;
    logic        halt_req;
    logic        halt_timeout;

    trigger_csr_ctrl #(.DATA_WIDTH(32), .ACK_TIMEOUT(4)) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .csr_req     (csr_req),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_ack     (csr_ack),
        .csr_rdata   (csr_rdata),
        .csr_err     (csr_err),
        .dbg_mode    (dbg_mode),
        .trig_hit    (trig_hit),
        .halt_ack    (halt_ack),
        .tdata1_t0   (tdata1_t0),
        .tdata1_t1   (tdata1_t1),
        .tdata2_t0   (tdata2_t0),
        .tdata2_t1   (tdata2_t1),
        .tdata3_t0   (tdata3_t0),
        .tdata3_t1   (tdata3_t1),
        .halt_req    (halt_req),
        .halt_timeout(halt_timeout)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   acc_id   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Scoreboard monitor: every ack must match the oldest outstanding expectation.
    always @(negedge cpu_clk) begin
        if (csr_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", {31'h0, csr_ack}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("csr_err#%0d", e.id), {31'h0, csr_err}, {31'h0, e.err});
                if (e.chk_rd) chk($sformatf("csr_rdata#%0d", e.id), csr_rdata, e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // One CSR access: request sampled at the next edge, ack cycle follows.
    task automatic csr(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input logic [1:0] hit);
        exp_t e;
        e.id = acc_id; e.rdata = exp_rd; e.err = exp_err; e.chk_rd = !we;
        acc_id++;
        exp_q.push_back(e);
        csr_req = 1'b1; csr_we = we; csr_addr = addr; csr_wdata = wdata; trig_hit = hit;
        tick();
        csr_req = 1'b0; csr_we = 1'b0; trig_hit = 2'b00;
        tick();
    endtask

    initial begin
        // Reset state
        tick(); tick();
        cpu_rst = 1'b0;
        chk("rst_tdata1_t0", tdata1_t0, 32'h2000_0000);
        chk("rst_tdata1_t1", tdata1_t1, 32'h2000_0000);
        chk("rst_tdata2_t0", tdata2_t0, 32'h0);
        chk("rst_tdata3_t1", tdata3_t1, 32'h0);
        chk("rst_halt_req",  {31'h0, halt_req}, 32'h0);
        chk("rst_csr_ack",   {31'h0, csr_ack}, 32'h0);
        chk("rst_csr_rdata", csr_rdata, 32'h0);

        // Basic reads, tinfo, unmapped
        csr(1'b0, 12'h7A1, 32'h0, 32'h2000_0000, 1'b0, 2'b00);
        csr(1'b0, 12'h7A4, 32'h0, 32'h0000_0004, 1'b0, 2'b00);
        csr(1'b1, 12'h7A4, 32'hFFFF_FFFF, 32'h0, 1'b1, 2'b00);
        csr(1'b0, 12'h7A4, 32'h0, 32'h0000_0004, 1'b0, 2'b00);
        csr(1'b0, 12'h7A5, 32'h0, 32'h0, 1'b1, 2'b00);

        // tselect and per-trigger tdata2
        csr(1'b1, 12'h7A0, 32'h1, 32'h0, 1'b0, 2'b00);
        csr(1'b1, 12'h7A2, 32'h8000_0100, 32'h0, 1'b0, 2'b00);
        chk("tdata2_t1_wr", tdata2_t1, 32'h8000_0100);
        chk("tdata2_t0_keep", tdata2_t0, 32'h0);
        csr(1'b1, 12'h7A0, 32'h5, 32'h0, 1'b0, 2'b00);
        csr(1'b0, 12'h7A0, 32'h0, 32'h1, 1'b0, 2'b00);

        // dmode lock on trigger 1
        dbg_mode = 1'b1;
        csr(1'b1, 12'h7A1, 32'h2800_1044, 32'h0, 1'b0, 2'b00);
        chk("tdata1_t1_dmode", tdata1_t1, 32'h2800_1044);
        dbg_mode = 1'b0;
        csr(1'b1, 12'h7A2, 32'h0000_1234, 32'h0, 1'b1, 2'b00);
        chk("tdata2_t1_locked", tdata2_t1, 32'h8000_0100);
        csr(1'b1, 12'h7A1, 32'h2000_0000, 32'h0, 1'b1, 2'b00);
        csr(1'b0, 12'h7A1, 32'h0, 32'h2800_1044, 1'b0, 2'b00);
        dbg_mode = 1'b1;
        csr(1'b1, 12'h7A1, 32'h7000_0000, 32'h0, 1'b0, 2'b00);
        csr(1'b0, 12'h7A1, 32'h0, 32'h0000_0000, 1'b0, 2'b00);
        dbg_mode = 1'b0;

        // dmode forced to 0 outside debug mode, trigger 0
        csr(1'b1, 12'h7A0, 32'h0, 32'h0, 1'b0, 2'b00);
        csr(1'b1, 12'h7A1, 32'h2800_0004, 32'h0, 1'b0, 2'b00);
        chk("tdata1_t0_nodmode", tdata1_t0, 32'h2000_0004);

        // Dual hit -> single halt request, ack, exit
        trig_hit = 2'b11;
        tick();
        trig_hit = 2'b00;
        chk("hit_t0", tdata1_t0, 32'h2010_0004);
        chk("hit_t1", tdata1_t1, 32'h0010_0000);
        chk("halt_req_set", {31'h0, halt_req}, 32'h1);
        tick(); tick();
        chk("halt_req_hold", {31'h0, halt_req}, 32'h1);
        halt_ack = 1'b1; dbg_mode = 1'b1;
        tick();
        halt_ack = 1'b0;
        chk("halt_req_ack_drop", {31'h0, halt_req}, 32'h0);
        chk("no_timeout_ack", {31'h0, halt_timeout}, 32'h0);
        trig_hit = 2'b01;
        tick();
        trig_hit = 2'b00;
        chk("wait_exit_ignore", {31'h0, halt_req}, 32'h0);
        dbg_mode = 1'b0;
        tick();
        trig_hit = 2'b10;
        tick();
        trig_hit = 2'b00;
        chk("rehit_halt_req", {31'h0, halt_req}, 32'h1);
        halt_ack = 1'b1; dbg_mode = 1'b1;
        tick();
        halt_ack = 1'b0; dbg_mode = 1'b0;
        tick();

        // Timeout: halt_req held 4 cycles then one timeout pulse
        trig_hit = 2'b01;
        tick();
        trig_hit = 2'b00;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("to_req_%0d", k), {31'h0, halt_req}, 32'h1);
            chk($sformatf("to_pulse_%0d", k), {31'h0, halt_timeout}, 32'h0);
            tick();
        end
        chk("to_req_3", {31'h0, halt_req}, 32'h1);
        tick();
        chk("to_req_drop", {31'h0, halt_req}, 32'h0);
        chk("to_pulse", {31'h0, halt_timeout}, 32'h1);
        tick();
        chk("to_pulse_end", {31'h0, halt_timeout}, 32'h0);

        // Software clear racing a hardware set: set wins
        csr(1'b1, 12'h7A1, 32'h2000_0004, 32'h0, 1'b0, 2'b01);
        chk("set_wins", tdata1_t0, 32'h2010_0004);
        chk("halt_req_race", {31'h0, halt_req}, 32'h1);

        // Reset during HALT_REQ
        cpu_rst = 1'b1;
        tick();
        cpu_rst = 1'b0;
        chk("rst2_halt_req", {31'h0, halt_req}, 32'h0);
        chk("rst2_tdata1_t0", tdata1_t0, 32'h2000_0000);
        chk("rst2_tdata1_t1", tdata1_t1, 32'h2000_0000);
        chk("rst2_tdata2_t1", tdata2_t1, 32'h0);
        csr(1'b0, 12'h7A0, 32'h0, 32'h0, 1'b0, 2'b00);

        // Read data reflects state before a same-cycle hit set
        csr(1'b0, 12'h7A1, 32'h0, 32'h2000_0000, 1'b0, 2'b01);
        chk("hit_after_read", tdata1_t0, 32'h2010_0000);

        tick(); tick();
        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
